// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the core's single data-memory port: round-robin grant, locked bursts, read-data return.
// Define DMEMARB_FIXED_PRIO_EN to make port 0 always win contention in IDLE.
module dmem_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] memaddr,
    output logic [31:0] memdatain,
    output logic [2:0]  memop,
    output logic        memwe,
    input  logic [31:0] memdataout
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    // A beat taken while cnt equals this value is the last one the owner gets.
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state_reg, state_next;
    logic            last_reg, last_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      rd_pend_reg, rd_pend_next;

    logic [1:0]      req_vec, lock_vec, we_vec, gnt_raw, gnt_vec, rvalid_vec;
    logic [31:0]     rdata_arr [2];
    logic            win, own;

    assign req_vec  = {req1, req0};
    assign lock_vec = {lock1, lock0};
    assign we_vec   = {we1, we0};

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        gnt_raw    = 2'b00;
        win        = 1'b0;
        own        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_vec == 2'b11) begin
`ifdef DMEMARB_FIXED_PRIO_EN
                    win = 1'b0;
`else
                    win = ~last_reg;
`endif
                end else begin
                    win = req_vec[1];
                end
                if (|req_vec) begin
                    gnt_raw[win] = 1'b1;
                    last_next    = win;
                    if (lock_vec[win]) begin
                        state_next = win ? OWN1 : OWN0;
                        cnt_next   = CW'(1);
                    end
                end
            end
            OWN0, OWN1: begin
                own = (state_reg == OWN1);
                if (req_vec[own]) begin
                    gnt_raw[own] = 1'b1;
                    if (lock_vec[own] && (cnt_reg < CNT_LAST)) begin
                        cnt_next = cnt_reg + CW'(1);
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign gnt_vec = reset ? gnt_raw : 2'b00;
    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];

    always_comb begin
        memaddr   = '0;
        memdatain = '0;
        memop     = '0;
        memwe     = 1'b0;
        if (gnt_vec[0]) begin
            memaddr   = addr0;
            memdatain = wdata0;
            memop     = op0;
            memwe     = we0;
        end else if (gnt_vec[1]) begin
            memaddr   = addr1;
            memdatain = wdata1;
            memop     = op1;
            memwe     = we1;
        end
    end

    // Read return: the RAM answers one cycle after issue; gating with reset
    // drops a read whose response would land inside a reset cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign rd_pend_next[gi] = gnt_vec[gi] & ~we_vec[gi];
            assign rvalid_vec[gi]   = rd_pend_reg[gi] & reset;
            assign rdata_arr[gi]    = rvalid_vec[gi] ? memdataout : 32'd0;
        end
    endgenerate

    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];
    assign rdata0  = rdata_arr[0];
    assign rdata1  = rdata_arr[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            cnt_reg     <= '0;
            rd_pend_reg <= 2'b00;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            rd_pend_reg <= rd_pend_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus a locked-burst sequence, read data checked through a scoreboard.
module tb_dmem_arbiter;

`ifdef DMEMARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  op0, op1;
    logic        gnt0, gnt1, rvalid0, rvalid1, memwe;
    logic [31:0] rdata0, rdata1, memaddr, memdatain, memdataout;
    logic [2:0]  memop;

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_BURST(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .memaddr(memaddr), .memdatain(memdatain), .memop(memop), .memwe(memwe),
        .memdataout(memdataout)
    );

    // Data RAM with 1-cycle synchronous read
    logic [31:0] ram    [256];
    logic [31:0] shadow [256];
    always_ff @(posedge clock) begin
        if (memwe) ram[memaddr[9:2]] <= memdatain;
        memdataout <= ram[memaddr[9:2]];
    end

    typedef struct {
        logic        rst_n;
        logic        req0, lock0, we0;
        logic [31:0] addr0;
        logic        req1, lock1, we1;
        logic [31:0] addr1;
        logic [31:0] wdata;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_gnt_fp;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } sb_t;

    sb_t  sb [$];
    vec_t tbl [22];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic vec_t mk(logic rst_n, logic r0, logic l0, logic w0, logic [31:0] a0,
                                logic r1, logic l1, logic w1, logic [31:0] a1,
                                logic [31:0] wd, logic [1:0] eg, logic [1:0] egf);
        vec_t v;
        v.rst_n = rst_n; v.req0 = r0; v.lock0 = l0; v.we0 = w0; v.addr0 = a0;
        v.req1 = r1; v.lock1 = l1; v.we1 = w1; v.addr1 = a1; v.wdata = wd;
        v.exp_gnt = eg; v.exp_gnt_fp = egf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v);
        logic [1:0]  eg, erv;
        logic [31:0] erd0, erd1, ea, ed;
        logic [2:0]  eo;
        logic        ew;
        sb_t         it;
        reset = v.rst_n;
        req0 = v.req0; lock0 = v.lock0; we0 = v.we0; addr0 = v.addr0;
        req1 = v.req1; lock1 = v.lock1; we1 = v.we1; addr1 = v.addr1;
        wdata1 = v.wdata;
        wdata0 = v.wdata ^ 32'h1111_1111;
        @(negedge clock);
        eg  = FIXED ? v.exp_gnt_fp : v.exp_gnt;
        erv = 2'b00; erd0 = '0; erd1 = '0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            if (v.rst_n) begin
                erv[it.port] = 1'b1;
                if (it.port) erd1 = it.data;
                else         erd0 = it.data;
            end
        end
        ea = '0; ed = '0; eo = '0; ew = 1'b0;
        if (eg[0]) begin ea = v.addr0; ed = wdata0; eo = op0; ew = v.we0; end
        else if (eg[1]) begin ea = v.addr1; ed = wdata1; eo = op1; ew = v.we1; end
        check("gnt",       {30'd0, gnt1, gnt0},       {30'd0, eg});
        check("memaddr",   memaddr,                   ea);
        check("memdatain", memdatain,                 ed);
        check("memop_we",  {28'd0, memop, memwe},     {28'd0, eo, ew});
        check("rvalid",    {30'd0, rvalid1, rvalid0}, {30'd0, erv});
        check("rdata0",    rdata0,                    erd0);
        check("rdata1",    rdata1,                    erd1);
        if (eg[0] && !v.we0) sb.push_back('{1'b0, shadow[v.addr0[9:2]]});
        if (eg[1] && !v.we1) sb.push_back('{1'b1, shadow[v.addr1[9:2]]});
        if (eg[0] && v.we0)  shadow[v.addr0[9:2]] = wdata0;
        if (eg[1] && v.we1)  shadow[v.addr1[9:2]] = wdata1;
        $display("cyc %0d rst_n=%b req=%b%b gnt=%b%b memaddr=%h memwe=%b rvalid=%b%b rdata0=%h rdata1=%h",
                 cyc, v.rst_n, v.req1, v.req0, gnt1, gnt0, memaddr, memwe, rvalid1, rvalid0, rdata0, rdata1);
        cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [1:0] eg;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'hC0DE_0000 + 32'(i * 4);
            shadow[i] = 32'hC0DE_0000 + 32'(i * 4);
        end
        op0 = 3'b010;
        op1 = 3'b101;
        //            rst  r0 l0 w0 addr0    r1 l1 w1 addr1    wdata          rr     fixed
        tbl[0]  = mk(1'b0, 1, 0, 0, 32'h100, 1, 0, 0, 32'h200, 32'h0,        2'b00, 2'b00);
        tbl[1]  = mk(1'b0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        2'b00, 2'b00);
        tbl[2]  = mk(1'b1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        2'b00, 2'b00);
        tbl[3]  = mk(1'b1, 1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   32'h0,        2'b01, 2'b01);
        tbl[4]  = mk(1'b1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        2'b00, 2'b00);
        tbl[5]  = mk(1'b1, 1, 0, 0, 32'h104, 1, 0, 0, 32'h204, 32'h0,        2'b10, 2'b01);
        tbl[6]  = mk(1'b1, 1, 0, 0, 32'h108, 1, 0, 0, 32'h208, 32'h0,        2'b01, 2'b01);
        tbl[7]  = mk(1'b1, 1, 0, 0, 32'h10C, 1, 0, 0, 32'h20C, 32'h0,        2'b10, 2'b01);
        tbl[8]  = mk(1'b1, 1, 0, 0, 32'h110, 1, 0, 0, 32'h210, 32'h0,        2'b01, 2'b01);
        tbl[9]  = mk(1'b1, 0, 0, 0, 32'h0,   1, 0, 1, 32'h20,  32'hDEADBEEF, 2'b10, 2'b10);
        tbl[10] = mk(1'b1, 1, 0, 0, 32'h20,  0, 0, 0, 32'h0,   32'h0,        2'b01, 2'b01);
        tbl[11] = mk(1'b1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        2'b00, 2'b00);
        tbl[12] = mk(1'b1, 1, 1, 0, 32'h120, 0, 0, 0, 32'h0,   32'h0,        2'b01, 2'b01);
        tbl[13] = mk(1'b1, 1, 1, 0, 32'h124, 1, 0, 0, 32'h224, 32'h0,        2'b01, 2'b01);
        tbl[14] = mk(1'b1, 0, 0, 0, 32'h0,   1, 0, 0, 32'h228, 32'h0,        2'b00, 2'b00);
        tbl[15] = mk(1'b1, 0, 0, 0, 32'h0,   1, 0, 0, 32'h22C, 32'h0,        2'b10, 2'b10);
        tbl[16] = mk(1'b1, 1, 1, 0, 32'h130, 0, 0, 0, 32'h0,   32'h0,        2'b01, 2'b01);
        tbl[17] = mk(1'b1, 1, 1, 0, 32'h134, 1, 0, 0, 32'h234, 32'h0,        2'b01, 2'b01);
        tbl[18] = mk(1'b0, 1, 1, 0, 32'h138, 1, 0, 0, 32'h238, 32'h0,        2'b00, 2'b00);
        tbl[19] = mk(1'b0, 1, 1, 0, 32'h13C, 1, 0, 0, 32'h23C, 32'h0,        2'b00, 2'b00);
        tbl[20] = mk(1'b1, 1, 0, 0, 32'h140, 1, 0, 0, 32'h240, 32'h0,        2'b01, 2'b01);
        tbl[21] = mk(1'b1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        2'b00, 2'b00);

        reset = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 22; i++) run_cycle(tbl[i]);

        // Port 1 locked for 12 cycles against a waiting port 0: 8-beat cap, then port 0, then port 1 again.
        for (int k = 0; k < 14; k++) begin
            if (k <= 7)       eg = 2'b10;
            else if (k == 8)  eg = 2'b01;
            else if (k < 12)  eg = FIXED ? 2'b01 : 2'b10;
            else              eg = 2'b00;
            v = mk(1'b1, (k >= 1 && k < 12), 1'b0, 1'b0, 32'h180 + 32'(k * 4),
                   (k < 12), (k < 12), 1'b0, 32'h300 + 32'(k * 4), 32'h0, eg, eg);
            run_cycle(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
